// File: rtl/cella_cmd_sched.sv
// cella_cmd_sched: FIFO-buffered command scheduler for the CIM array controller.
// Ports: clk, rst_n (async, active low); cmd_valid/cmd_ready/cmd_op/cmd_bank/cmd_word
// host side; op_code/bank_sel/word array side; busy, done, done_op status.
// Optional CELLA_SCHED_PERF_EN adds perf_clr input and mac_cnt/wr_cnt outputs.
module cella_cmd_sched #(
  parameter int DEPTH   = 4,
  parameter int MAC_CYC = 4,
  parameter int RD_CYC  = 2,
  parameter int WR_CYC  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_bank,
  input  logic [7:0] cmd_word,
  output logic [1:0] op_code,
  output logic [3:0] bank_sel,
  output logic [7:0] word,
  output logic       busy,
  output logic       done,
  output logic [1:0] done_op
`ifdef CELLA_SCHED_PERF_EN
  ,
  input  logic        perf_clr,
  output logic [15:0] mac_cnt,
  output logic [15:0] wr_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;

  localparam logic [1:0] OP_MAC = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] bank;
    logic [7:0] word;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_GAP
  } state_t;

  state_t        state;
  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] cnt;
  logic          rdy_en;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          last;
  logic          gap_need;

  function automatic logic [CW-1:0] hold_cyc(input logic [1:0] op);
    logic [CW-1:0] c;
    unique case (op)
      OP_MAC:  c = CW'(MAC_CYC - 1);
      OP_RD:   c = CW'(RD_CYC - 1);
      default: c = CW'(WR_CYC - 1);
    endcase
    return c;
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // rdy_en keeps ready low through reset and one cycle past release.
  assign cmd_ready = rdy_en & ~full;
  assign push      = cmd_valid & cmd_ready & (cmd_op != OP_NOP);
  assign head      = mem[rd_ptr[AW-1:0]];
  assign last      = (state == S_EXEC) && (cnt == '0);
  // Write turnaround: next command hits the bank just written.
  assign gap_need  = (op_code == OP_WR) && (head.bank == bank_sel);
  assign busy      = (state != S_IDLE) | ~empty;
  assign done      = last;
  assign done_op   = last ? op_code : 2'b00;

  always_comb begin
    pop = 1'b0;
    unique case (1'b1)
      state == S_IDLE: pop = ~empty;
      state == S_EXEC: pop = last & ~empty & ~gap_need;
      state == S_GAP:  pop = 1'b1;
      default:         pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{op: cmd_op, bank: cmd_bank, word: cmd_word};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_code  <= OP_NOP;
      bank_sel <= '0;
      word     <= '0;
      cnt      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            op_code  <= head.op;
            bank_sel <= head.bank;
            word     <= head.word;
            cnt      <= hold_cyc(head.op);
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (pop) begin
            op_code  <= head.op;
            bank_sel <= head.bank;
            word     <= head.word;
            cnt      <= hold_cyc(head.op);
          end else if (!empty) begin
            op_code <= OP_NOP;
            state   <= S_GAP;
          end else begin
            op_code <= OP_NOP;
            state   <= S_IDLE;
          end
        end
        S_GAP: begin
          op_code  <= head.op;
          bank_sel <= head.bank;
          word     <= head.word;
          cnt      <= hold_cyc(head.op);
          state    <= S_EXEC;
        end
        default: begin
          op_code <= OP_NOP;
          state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CELLA_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_cnt <= '0;
      wr_cnt  <= '0;
    end else if (perf_clr) begin
      mac_cnt <= '0;
      wr_cnt  <= '0;
    end else if (done) begin
      if (op_code == OP_MAC && mac_cnt != 16'hFFFF) mac_cnt <= mac_cnt + 16'd1;
      if (op_code == OP_WR && wr_cnt != 16'hFFFF)   wr_cnt  <= wr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cella_cmd_sched.sv
// tb_cella_cmd_sched: scoreboard bench for cella_cmd_sched.
// Accepted commands get an expected issue window; a monitor checks every cycle.
module tb_cella_cmd_sched;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_bank;
  logic [7:0] cmd_word;
  logic [1:0] op_code;
  logic [3:0] bank_sel;
  logic [7:0] word;
  logic       busy;
  logic       done;
  logic [1:0] done_op;
`ifdef CELLA_SCHED_PERF_EN
  logic        perf_clr;
  logic [15:0] mac_cnt;
  logic [15:0] wr_cnt;
  int          mac_m;
  int          wr_m;
  bit          perf_on;
`endif

  cella_cmd_sched #(
    .DEPTH(DEPTH), .MAC_CYC(4), .RD_CYC(2), .WR_CYC(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_bank(cmd_bank), .cmd_word(cmd_word),
    .op_code(op_code), .bank_sel(bank_sel), .word(word),
    .busy(busy), .done(done), .done_op(done_op)
`ifdef CELLA_SCHED_PERF_EN
    , .perf_clr(perf_clr), .mac_cnt(mac_cnt), .wr_cnt(wr_cnt)
`endif
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] bank;
    logic [7:0] word;
    int         s;
    int         d;
    bit         gap;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   edge_n;
  int   last_d;
  int   last_op;
  int   last_bank;
  int   n_acc;
  int   n_done_seen;
  bit   rdy_seen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cyc_of(input logic [1:0] op);
    return (op == 2'b00) ? 4 : (op == 2'b01) ? 2 : 3;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    last_d    = -1;
    last_op   = 3;
    last_bank = 0;
    rdy_seen  = 1'b0;
`ifdef CELLA_SCHED_PERF_EN
    mac_m = 0;
    wr_m  = 0;
`endif
  endtask

  // Handshake logger: computes when each accepted command must issue.
  always @(posedge clk) begin
    exp_t e;
    int   a;
    edge_n++;
    if (rst_n) begin
      if (cmd_valid && cmd_ready && cmd_op != 2'b11) begin
        a      = edge_n;
        e.op   = cmd_op;
        e.bank = cmd_bank;
        e.word = cmd_word;
        if (a <= last_d) begin
          e.gap = (last_op == 2) && (last_bank == int'(cmd_bank));
          e.s   = last_d + 1 + (e.gap ? 1 : 0);
        end else begin
          e.gap = 1'b0;
          e.s   = a + 1;
        end
        e.d       = e.s + cyc_of(cmd_op) - 1;
        last_d    = e.d;
        last_op   = int'(cmd_op);
        last_bank = int'(cmd_bank);
        n_acc++;
        q.push_back(e);
      end
      rdy_seen = 1'b1;
    end
  end

  // Monitor: compares DUT outputs against the scheduled expectations.
  initial begin
    forever begin
      int  k;
      int  pend;
      bit  act;
      bit  xdone;
      @(negedge clk);
      #1;
      k = edge_n;
      if (done) n_done_seen++;
      if (!rst_n) begin
        chk("rst_op_code", 32'(op_code), 3);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
      end else begin
        act   = (q.size() > 0) && (q[0].s <= k);
        xdone = act && (q[0].d == k);
        pend  = 0;
        foreach (q[i]) if (q[i].s > k) pend++;
        chk("op_code", 32'(op_code), act ? 32'(q[0].op) : 3);
        chk("done", 32'(done), 32'(xdone));
        chk("cmd_ready", 32'(cmd_ready), (rdy_seen && pend < DEPTH) ? 1 : 0);
        chk("busy", 32'(busy), (q.size() > 0) ? 1 : 0);
        if (act) begin
          chk("bank_sel", 32'(bank_sel), 32'(q[0].bank));
          chk("word", 32'(word), 32'(q[0].word));
        end
        if (xdone) chk("done_op", 32'(done_op), 32'(q[0].op));
        if (!act && q.size() > 0 && q[0].gap && k == q[0].s - 1)
          chk("gap_bank", 32'(bank_sel), 32'(q[0].bank));
`ifdef CELLA_SCHED_PERF_EN
        chk("mac_cnt", 32'(mac_cnt), mac_m);
        chk("wr_cnt", 32'(wr_cnt), wr_m);
        if (perf_clr) begin
          mac_m = 0;
          wr_m  = 0;
        end else if (xdone) begin
          if (q[0].op == 2'b00 && mac_m < 65535) mac_m++;
          if (q[0].op == 2'b10 && wr_m < 65535) wr_m++;
        end
`endif
        if (xdone) void'(q.pop_front());
      end
    end
  end

`ifdef CELLA_SCHED_PERF_EN
  always @(negedge clk) perf_clr = perf_on && ($urandom_range(0, 9) == 0);
`endif

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send(input logic [1:0] op, input logic [3:0] bank,
                      input logic [7:0] w);
    int guard;
    guard     = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_bank  = bank;
    cmd_word  = w;
    #1;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout op %0d bank %0d", op, bank);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    edge_n      = 0;
    n_acc       = 0;
    n_done_seen = 0;
    cmd_valid   = 1'b0;
    cmd_op      = 2'b11;
    cmd_bank    = '0;
    cmd_word    = '0;
`ifdef CELLA_SCHED_PERF_EN
    perf_on  = 1'b0;
    perf_clr = 1'b0;
`endif
    rst_n = 1'b0;
    clear_model();
    @(negedge clk);
    do_reset();

    send(2'b00, 4'd3, 8'h5A);
    drain();

    send(2'b01, 4'd2, 8'h11);
    send(2'b10, 4'd7, 8'h22);
    send(2'b00, 4'd1, 8'h33);
    drain();

    send(2'b10, 4'd5, 8'h44);
    send(2'b01, 4'd5, 8'h55);
    drain();
    send(2'b10, 4'd5, 8'h66);
    send(2'b01, 4'd6, 8'h77);
    drain();

    for (int i = 0; i < 6; i++) send(2'b00, 4'(i), 8'(8'hA0 + i));
    drain();

    send(2'b00, 4'd4, 8'h01);
    send(2'b11, 4'd4, 8'h02);
    send(2'b01, 4'd4, 8'h03);
    send(2'b11, 4'd9, 8'h04);
    send(2'b10, 4'd4, 8'h05);
    drain();

    send(2'b00, 4'd9, 8'hEE);
    send(2'b01, 4'd9, 8'hEF);
    repeat (2) @(negedge clk);
    do_reset();
    n_acc       = 0;
    n_done_seen = 0;

`ifdef CELLA_SCHED_PERF_EN
    perf_on = 1'b1;
`endif
    for (int i = 0; i < 300; i++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
`ifdef CELLA_SCHED_PERF_EN
    perf_on = 1'b0;
`endif
    chk("done_count", n_done_seen, n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cella_cmd_sched.md
Name: cella_cmd_sched

Overview:
- Command scheduler sitting in front of the CIM array controller.
- Buffers host commands (MAC / read / write with bank and word) in a small FIFO.
- Issues each command on op_code/bank_sel/word and holds it for its op-specific cycle count.
- Inserts write-to-same-bank turnaround gaps and reports completion per command.

Parameters:
DEPTH, 4, command FIFO depth; power of two, minimum 2
MAC_CYC, 4, cycles op_code 2'b00 (MAC) is held; minimum 1
RD_CYC, 2, cycles op_code 2'b01 (read) is held; minimum 1
WR_CYC, 3, cycles op_code 2'b10 (write) is held; minimum 1

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  scheduler can accept a command
cmd_op  in  2  00 MAC, 01 read, 10 write, 11 NOP
cmd_bank  in  4  target bank index 0..15
cmd_word  in  8  word/row address
op_code  out  2  to array controller; 2'b11 when idle or in a gap
bank_sel  out  4  to array controller
word  out  8  to array controller
busy  out  1  FSM not IDLE or FIFO non-empty
done  out  1  one-cycle pulse on the last hold cycle of a command
done_op  out  2  op of the completing command; valid only while done=1

Behaviour:
- Reset (async assert, sync release): FIFO emptied; FSM to IDLE; op_code=2'b11, bank_sel=0, word=0, done=0, done_op=0, busy=0; write-history flag cleared. cmd_ready=1 one cycle after release.
- Reset asserted mid-command: the command is abandoned, with no done pulse, and all queued commands are discarded.
- Accept rule:
  - A handshake occurs on an edge with cmd_valid & cmd_ready.
  - cmd_ready = !full and is registered-free (combinational from FIFO count).
  - There is no push-through when full, even if a pop occurs on the same edge.
- NOP (cmd_op=11): handshaken and dropped. It is never enqueued and produces no done.
- FIFO:
  - Pointer width log2(DEPTH)+1; wrap-around by pointer MSB.
  - Simultaneous push and pop with a non-full, non-empty FIFO keeps count unchanged.
- FSM states: IDLE, EXEC, GAP.
  - IDLE: op_code=11. If FIFO non-empty, pop the head on the edge, register op/bank/word to outputs, load cnt = op_cycles-1, and go to EXEC.
  - Latency: a command enqueued on edge E0 into an empty FIFO in IDLE appears on op_code after edge E1.
  - EXEC: outputs held. cnt decrements each cycle. When cnt==0:
    - done=1 and done_op=current op.
    - If the FIFO is non-empty and no gap is needed, pop the next command on the same edge (back-to-back, zero bubble).
    - Else if a gap is needed, go to GAP.
    - Else go to IDLE with op_code=11.
  - Gap needed when the completing op is a write (10) and the FIFO head targets the same bank, any op.
  - GAP: exactly one cycle with op_code=11 and bank_sel/word unchanged. Then pop the head and go to EXEC.
- A command enqueued in the same cycle the FIFO goes empty at cnt==0 is not visible to the pop decision. It is issued via IDLE on the following edge.
- busy is combinational: (state!=IDLE) | !empty.

Optional Feature:
- Macro CELLA_SCHED_PERF_EN.
- Defined:
  - Adds outputs mac_cnt[15:0] and wr_cnt[15:0], counting completed MAC and write commands (incremented on done).
  - Counters saturate at 16'hFFFF and reset to 0.
  - Adds input perf_clr, which synchronously zeroes both counters. perf_clr wins over a same-cycle increment.
- Undefined: these ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then single MAC (bank 3, word 8'h5A) into empty queue -> op_code=00, bank_sel=3, word=5A after edge E1 for exactly 4 cycles; done=1 with done_op=00 on the 4th; then op_code=11 and busy=0.
- Push read b2, write b7, MAC b1 back-to-back -> op_code sequence 01x2, 10x3, 00x4 with no 11 between; three done pulses, each with correct done_op.
- Write b5 then read b5 queued -> 10x3, one cycle of 11 with bank_sel=5, then 01x2. Repeating with read b6 gives no gap.
- Hold cmd_valid high with MAC commands while the array is stalled -> after DEPTH=4 accepts, cmd_ready=0. It returns to 1 the cycle after the first pop. No command is lost or duplicated (check via done count).
- NOP mixed between commands -> accepted with cmd_ready=1, no op_code=11 hold cycles added, no done. Then assert rst_n=0 mid-MAC -> op_code=11 and cmd_ready=0 immediately, FIFO empty after release, no done.
- With CELLA_SCHED_PERF_EN: run 3 MAC + 2 writes -> mac_cnt=3, wr_cnt=2. perf_clr coinciding with a MAC done -> mac_cnt=0.
